// File: rtl/video_grayscale_stage_if.sv
// video_grayscale_stage_if: RGB565 pixel stream into and out of the grayscale stage, plus frame status
interface video_grayscale_stage_if;
  logic [15:0] data_in;
  logic        valid_in;
  logic        startofpacket_in;
  logic        endofpacket_in;
  logic        ready_out;
  logic [15:0] data_out;
  logic        valid_out;
  logic        startofpacket_out;
  logic        endofpacket_out;
  logic        ready_in;
  logic        frame_error;
  logic [15:0] frame_count;
  modport slave (
    input  data_in, valid_in, startofpacket_in, endofpacket_in, ready_in,
    output ready_out, data_out, valid_out, startofpacket_out, endofpacket_out, frame_error, frame_count
  );
  modport master (
    output data_in, valid_in, startofpacket_in, endofpacket_in, ready_in,
    input  ready_out, data_out, valid_out, startofpacket_out, endofpacket_out, frame_error, frame_count
  );
endinterface

// File: rtl/video_grayscale_stage.sv
// video_grayscale_stage: RGB565 to grey RGB565 through a 2-entry skid buffer; geometry check under VIDEO_FRAME_CHECK_EN
module video_grayscale_stage #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input logic clk,
  input logic reset,
  video_grayscale_stage_if.slave s
);
  logic [7:0]  r8, g8, b8;
  logic [15:0] sum;
  logic [5:0]  y6;
  logic [17:0] beat, out_q, out_d, skid_q, skid_d;
  logic        vld_q, vld_d, full_q, full_d, acc, free;
  assign s.ready_out         = ~reset & ~full_q;
  assign s.valid_out         = vld_q;
  assign s.startofpacket_out = out_q[17];
  assign s.endofpacket_out   = out_q[16];
  assign s.data_out          = out_q[15:0];
  assign acc                 = s.valid_in & s.ready_out;
  assign free                = ~vld_q | s.ready_in;
  // luma of the incoming pixel, replicated into all three channels with its framing flags
  always_comb begin
    r8   = {s.data_in[15:11], s.data_in[15:13]};
    g8   = {s.data_in[10:5], s.data_in[10:9]};
    b8   = {s.data_in[4:0], s.data_in[4:2]};
    sum  = 16'd77 * r8 + 16'd150 * g8 + 16'd29 * b8;
    y6   = 6'(sum >> 10);
    beat = {s.startofpacket_in, s.endofpacket_in, y6[5:1], y6, y6[5:1]};
  end
  // output register refills from the skid first so beat order is kept
  always_comb begin
    vld_d  = free ? (full_q | acc) : vld_q;
    out_d  = free ? (full_q ? skid_q : (acc ? beat : out_q)) : out_q;
    full_d = free ? (full_q & acc) : (full_q | acc);
    skid_d = (acc & (full_q | ~free)) ? beat : skid_q;
  end
  // pipeline state
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= 1'b0;
      full_q <= 1'b0;
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      vld_q  <= vld_d;
      full_q <= full_d;
      out_q  <= out_d;
      skid_q <= skid_d;
    end
  end
`ifdef VIDEO_FRAME_CHECK_EN
  localparam logic [15:0] x_last = 16'(WIDTH - 1);
  localparam logic [15:0] y_last = 16'(HEIGHT - 1);
  logic [15:0] x_q, x_d, y_q, y_d, cnt_q, cnt_d;
  logic        err_q, err_d, at0, atl, bad;
  assign s.frame_error = err_q;
  assign s.frame_count = cnt_q;
  // raster position tracking: EOP ends a frame, a stray SOP restarts one, the last pixel wraps
  always_comb begin
    at0   = x_q == 16'd0 && y_q == 16'd0;
    atl   = x_q == x_last && y_q == y_last;
    bad   = (s.startofpacket_in ^ at0) | (s.endofpacket_in ^ atl);
    err_d = acc & bad;
    cnt_d = cnt_q + 16'(acc & s.endofpacket_in & ~bad);
    x_d   = ~acc ? x_q : s.endofpacket_in ? '0 : s.startofpacket_in ? 16'd1 : (atl | x_q == x_last) ? '0 : x_q + 16'd1;
    y_d   = ~acc ? y_q : (s.endofpacket_in | s.startofpacket_in | atl) ? '0 : x_q == x_last ? y_q + 16'd1 : y_q;
  end
  // checker state
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q   <= '0;
      y_q   <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  logic [31:0] unused_geom;
  assign unused_geom   = WIDTH + HEIGHT;
  assign s.frame_error = 1'b0;
  assign s.frame_count = '0;
`endif
endmodule

// File: tb/tb_video_grayscale_stage.sv
// tb_video_grayscale_stage: randomized scoreboard bench for the grayscale stage
module tb_video_grayscale_stage;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  int delivered = 0;
  logic [17:0] mdl[$];
  logic obs_ro, obs_vo, exp_ro, exp_vo, did_acc;
  logic [17:0] obs_b, exp_b;
  video_grayscale_stage_if vif();
  video_grayscale_stage #(.WIDTH(4), .HEIGHT(2)) dut (.clk(clk), .reset(reset), .s(vif.slave));
  always #5 clk = ~clk;
  function automatic logic [15:0] grey(input logic [15:0] p);
    int r, g, b, y;
    r = int'(p[15:11]);
    g = int'(p[10:5]);
    b = int'(p[4:0]);
    r = r * 8 + r / 4;
    g = g * 4 + g / 16;
    b = b * 8 + b / 4;
    y = (77 * r + 150 * g + 29 * b) / 256;
    return 16'((y / 8) * 2048 + (y / 4) * 32 + y / 8);
  endfunction
  task automatic cyc(input logic v, input logic [15:0] d, input logic sop, input logic eop, input logic rdy);
    logic dlv;
    vif.valid_in = v;
    vif.data_in = d;
    vif.startofpacket_in = sop;
    vif.endofpacket_in = eop;
    vif.ready_in = rdy;
    #1;
    obs_ro = vif.ready_out;
    obs_vo = vif.valid_out;
    obs_b = {vif.startofpacket_out, vif.endofpacket_out, vif.data_out};
    exp_ro = mdl.size() < 2;
    exp_vo = mdl.size() != 0;
    exp_b = '0;
    if (exp_vo) exp_b = mdl[0];
    did_acc = v & obs_ro;
    dlv = obs_vo & rdy;
    @(posedge clk);
    #1;
    if (dlv && mdl.size() != 0) begin
      void'(mdl.pop_front());
      delivered++;
    end
    if (did_acc) mdl.push_back({sop, eop, grey(d)});
  endtask
  task automatic test_reset;
    reset = 1'b1;
    vif.valid_in = 1'b1;
    vif.data_in = 16'hFFFF;
    vif.startofpacket_in = 1'b1;
    vif.endofpacket_in = 1'b1;
    vif.ready_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({vif.ready_out, vif.valid_out, vif.data_out, vif.startofpacket_out, vif.endofpacket_out, vif.frame_error, vif.frame_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs rdy=%b vld=%b data=%h sop=%b eop=%b ferr=%b fcnt=%0d want all 0", vif.ready_out, vif.valid_out, vif.data_out, vif.startofpacket_out, vif.endofpacket_out, vif.frame_error, vif.frame_count);
    end
    reset = 1'b0;
    vif.valid_in = 1'b0;
    #1;
    checks++;
    if (vif.ready_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_release ready_out=%b want 1", vif.ready_out);
    end
    mdl.delete();
  endtask
  task automatic test_values;
    logic [15:0] pin[4] = '{16'hFFFF, 16'h0000, 16'hF800, 16'h07E0};
    logic [15:0] pout[4] = '{16'hFFFF, 16'h0000, 16'h4A69, 16'h94B2};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, pin[i], 1'b0, 1'b0, 1'b1);
      checks++;
      if (vif.valid_out !== 1'b1 || vif.data_out !== pout[i]) begin
        errors++;
        $display("FAIL value_%0d in=%h got vld=%b data=%h want vld=1 data=%h", i, pin[i], vif.valid_out, vif.data_out, pout[i]);
      end
    end
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
  endtask
  task automatic test_stall;
    logic [15:0] beats[4] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};
    int i = 0;
    int falls = 0;
    logic prev = 1'b1;
    delivered = 0;
    for (int n = 0; n < 12; n++) begin
      cyc(i < 4, beats[i & 3], i == 0, i == 3, !(n >= 2 && n <= 4));
      checks++;
      if ({obs_ro, obs_vo} !== {exp_ro, exp_vo}) begin
        errors++;
        $display("FAIL stall_hs cycle %0d ready_out/valid_out got %b%b want %b%b", n, obs_ro, obs_vo, exp_ro, exp_vo);
      end
      if (exp_vo) begin
        checks++;
        if (obs_b !== exp_b) begin
          errors++;
          $display("FAIL stall_beat cycle %0d got %h want %h", n, obs_b, exp_b);
        end
      end
      if (prev && !obs_ro) falls++;
      prev = obs_ro;
      if (did_acc) i++;
    end
    checks++;
    if (falls != 1 || delivered != 4 || i != 4 || mdl.size() != 0) begin
      errors++;
      $display("FAIL stall_summary falls=%0d delivered=%0d accepted=%0d left=%0d want 1/4/4/0", falls, delivered, i, mdl.size());
    end
  endtask
  task automatic test_random;
    int acc_n = 0;
    int n = 0;
    delivered = 0;
    while (acc_n < 1000 && n < 20000) begin
      cyc($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9) < 6);
      checks++;
      if ({obs_ro, obs_vo} !== {exp_ro, exp_vo}) begin
        errors++;
        $display("FAIL random_hs cycle %0d ready_out/valid_out got %b%b want %b%b", n, obs_ro, obs_vo, exp_ro, exp_vo);
      end
      if (exp_vo) begin
        checks++;
        if (obs_b !== exp_b) begin
          errors++;
          $display("FAIL random_beat cycle %0d got %h want %h", n, obs_b, exp_b);
        end
      end
      if (did_acc) acc_n++;
      n++;
    end
    repeat (4) cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (acc_n != 1000 || delivered != 1000 || mdl.size() != 0) begin
      errors++;
      $display("FAIL random_summary accepted=%0d delivered=%0d left=%0d want 1000/1000/0", acc_n, delivered, mdl.size());
    end
  endtask
  task automatic test_reset_mid;
    cyc(1'b1, 16'h1111, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 16'h2222, 1'b0, 1'b0, 1'b0);
    checks++;
    if (vif.ready_out !== 1'b0) begin
      errors++;
      $display("FAIL midreset_skid ready_out=%b want 0", vif.ready_out);
    end
    reset = 1'b1;
    vif.valid_in = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({vif.ready_out, vif.valid_out, vif.data_out, vif.startofpacket_out, vif.endofpacket_out, vif.frame_error, vif.frame_count} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs rdy=%b vld=%b data=%h sop=%b eop=%b ferr=%b fcnt=%0d want all 0", vif.ready_out, vif.valid_out, vif.data_out, vif.startofpacket_out, vif.endofpacket_out, vif.frame_error, vif.frame_count);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    vif.valid_in = 1'b0;
    vif.ready_in = 1'b1;
    mdl.delete();
    #1;
    checks++;
    if (vif.ready_out !== 1'b1) begin
      errors++;
      $display("FAIL midreset_release ready_out=%b want 1", vif.ready_out);
    end
    for (int n = 0; n < 4; n++) begin
      cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (obs_vo !== 1'b0) begin
        errors++;
        $display("FAIL midreset_stale cycle %0d valid_out=%b data=%h want valid_out 0", n, obs_vo, obs_b);
      end
    end
  endtask
  task automatic test_frame;
    int len[3] = '{8, 6, 8};
`ifdef VIDEO_FRAME_CHECK_EN
    int exp_pulses[3] = '{0, 1, 0};
    int exp_cnt[3] = '{1, 1, 2};
`else
    int exp_pulses[3] = '{0, 0, 0};
    int exp_cnt[3] = '{0, 0, 0};
`endif
    for (int f = 0; f < 3; f++) begin
      int pulses = 0;
      logic at_eop = 1'b0;
      for (int k = 0; k <= len[f]; k++) begin
        cyc(k < len[f], 16'($urandom), k == 0, k == len[f] - 1, 1'b1);
        if (k < len[f]) begin
          checks++;
          if (!did_acc) begin
            errors++;
            $display("FAIL frame%0d_accept beat %0d not accepted, ready_out=%b want 1", f, k, obs_ro);
          end
        end
        if (exp_vo) begin
          checks++;
          if (obs_b !== exp_b) begin
            errors++;
            $display("FAIL frame%0d_beat %0d got %h want %h", f, k, obs_b, exp_b);
          end
        end
        if (k == len[f] - 1) at_eop = vif.frame_error;
        if (vif.frame_error === 1'b1) pulses++;
      end
      cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      if (vif.frame_error === 1'b1) pulses++;
      checks++;
      if (pulses != exp_pulses[f] || int'(at_eop) != exp_pulses[f]) begin
        errors++;
        $display("FAIL frame%0d_error pulses=%0d at_eop=%b want %0d", f, pulses, at_eop, exp_pulses[f]);
      end
      checks++;
      if (int'(vif.frame_count) != exp_cnt[f]) begin
        errors++;
        $display("FAIL frame%0d_count got %0d want %0d", f, vif.frame_count, exp_cnt[f]);
      end
    end
  endtask
  initial begin
    reset = 1'b1;
    vif.valid_in = 1'b0;
    vif.data_in = 16'h0;
    vif.startofpacket_in = 1'b0;
    vif.endofpacket_in = 1'b0;
    vif.ready_in = 1'b0;
    test_reset;
    test_values;
    test_stall;
    test_random;
    test_reset_mid;
    test_frame;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/video_grayscale_stage.md
# video_grayscale_stage

Processing stage of the video IP. It sits between the Avalon-ST sink side and `avalon_st_source_interface`, consuming RGB565 pixel beats and converting each pixel to grey, still in RGB565 form. It forwards startofpacket/endofpacket aligned with the data and decouples upstream from downstream back-pressure through a 2-entry skid buffer. Optionally it checks frame geometry against the configured resolution.

## Interface
- `WIDTH`, 320: pixels per line (frame check only)
- `HEIGHT`, 240: lines per frame (frame check only)

- `clk` in 1: clock, all logic on rising edge
- `reset` in 1: synchronous, active-high reset
- `data_in` in 16: RGB565 pixel {R[4:0],G[5:0],B[4:0]}
- `valid_in` in 1: upstream beat valid
- `startofpacket_in` in 1: first pixel of frame
- `endofpacket_in` in 1: last pixel of frame
- `ready_out` out 1: stage can accept a beat this cycle
- `data_out` out 16: grey pixel, RGB565
- `valid_out` out 1: output beat valid
- `startofpacket_out` out 1: aligned SOP
- `endofpacket_out` out 1: aligned EOP
- `ready_in` in 1: downstream ready
- `frame_error` out 1: one-cycle pulse on a geometry violation
- `frame_count` out 16: frames completed without error, wraps at 16'hFFFF→0

## Operation
- Accept when `valid_in & ready_out`. Deliver when `valid_out & ready_in`.
- Conversion is combinational on the input and is registered on accept:
  - Expand each channel to 8 bits: R8={R,R[4:2]}, G8={G,G[5:4]}, B8={B,B[4:2]}.
  - Y = (77·R8 + 150·G8 + 29·B8) >> 8, using a 16-bit unsigned sum that cannot overflow. Y is 8 bits.
  - `data_out` = {Y[7:3], Y[7:2], Y[7:3]}.
- Storage:
  - An output register holds data, SOP and EOP.
  - A skid register holds one extra beat.
  - `ready_out` = ~reset & ~skid_full.
- Output register empty, or delivering this cycle:
  - An accepted beat loads the output register.
  - If the skid is full, the skid beat moves to the output register first and the incoming beat goes into the skid. This case cannot occur, because `ready_out` is 0 while the skid is full.
- Output register full and stalled (`ready_in`=0): an accepted beat goes to the skid and `skid_full` sets.
- Skid full and output delivering: the skid beat moves to the output register and `skid_full` clears.
- Beat order is always preserved. No beat is dropped or duplicated.
- SOP and EOP are never altered. A beat with both SOP and EOP is passed through as-is.

## Timing
- Latency: a beat accepted in cycle n has `valid_out`=1 in cycle n+1.
- Throughput: 1 beat/cycle while `ready_in` stays 1.
- `ready_out` falls the cycle after a beat is captured into the skid. It rises the cycle after the skid drains.
- `ready_in` has no combinational path to `ready_out`.
- Reset:
  - While asserted: `valid_out`, `data_out`, `startofpacket_out`, `endofpacket_out`, `frame_error` = 0, `frame_count` = 0, `ready_out` = 0, skid cleared.
  - `ready_out` = 1 in the first cycle after deassertion.
- Reset mid-frame: in-flight beats are discarded, and the checker returns to expecting SOP.
- `valid_out` holds, with data stable, until delivered.

## Configuration
- `VIDEO_FRAME_CHECK_EN` defined:
  - x counter (0..WIDTH-1) and y counter (0..HEIGHT-1) advance on each accepted beat.
  - An error is any of:
    - SOP at a position other than (0,0); the counters restart at (1,0) after that beat.
    - EOP not at (WIDTH-1, HEIGHT-1).
    - Reaching (WIDTH-1, HEIGHT-1) without EOP.
    - A beat at (0,0) without SOP.
  - `frame_error` pulses for 1 cycle, the cycle after the offending accept.
  - `frame_count` increments the cycle after an error-free EOP accept.
  - After an EOP, with or without error, the counters return to (0,0).
  - Data flow is never blocked by errors.
- Not defined: no counters; `frame_error` and `frame_count` tied to 0.

## Test plan
- Data values, `ready_in`=1. Input 16'hFFFF→16'hFFFF; 16'h0000→16'h0000; 16'hF800→16'h4A69; 16'h07E0→16'h94B2. Each appears 1 cycle after accept.
- Stall: stream 4 beats, drop `ready_in` for 3 cycles after beat 1. Required:
  - `ready_out` falls exactly once the skid fills.
  - All 4 beats come out in order with no loss or duplication.
  - `valid_out` and data stay stable during the stall.
- Random `valid_in`/`ready_in`, 1000 beats: the output sequence equals the reference-model sequence, with SOP and EOP aligned.
- Reset mid-stream with the skid full:
  - All outputs read 0 during reset.
  - `ready_out`=1 in the first cycle after reset.
  - No stale beat is emitted.
- Frame check with WIDTH=4, HEIGHT=2, macro on:
  - Correct 8-beat frame → `frame_count`=1, no error.
  - EOP on beat 6 → one `frame_error` pulse, `frame_count` unchanged.
- Macro off, the same bad frame → `frame_error` stays 0 and data passes unchanged.
